// File: rtl/data_mem_unit_if.sv
// Request/response bus of the data-memory unit.
//   master : requester side (drives req_*, resp_ready; sees req_ready, resp_*)
//   slave  : memory unit side
// Signals:
//   req_valid/req_ready      request handshake
//   req_we, req_be           store flag and byte enables (be ignored for loads)
//   req_addr                 word index in the low address bits, upper bits wrap
//   req_data, req_tag        store data and ROB tag
//   resp_valid/resp_ready    response handshake
//   resp_tag, resp_data      tag and load data (0 for stores)
//   resp_is_store            response belongs to a store
interface data_mem_unit_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [DATA_W/8-1:0]   req_be;
   logic [31:0]           req_addr;
   logic [DATA_W-1:0]     req_data;
   logic [TAG_W-1:0]      req_tag;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [TAG_W-1:0]      resp_tag;
   logic [DATA_W-1:0]     resp_data;
   logic                  resp_is_store;

   modport master (
      output req_valid, req_we, req_be, req_addr, req_data, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_tag, resp_data, resp_is_store
   );

   modport slave (
      input  req_valid, req_we, req_be, req_addr, req_data, req_tag, resp_ready,
      output req_ready, resp_valid, resp_tag, resp_data, resp_is_store
   );
endinterface

// File: rtl/data_mem_unit.sv
// Pipelined data memory: request FIFO, in-order issue, byte-enabled stores,
// LATENCY-stage response pipeline with backpressure, and flush.
// Ports:
//   clk    clock, all state updates on posedge
//   rst    asynchronous active-low reset
//   bus    request/response bus (slave side)
//   flush  synchronous squash of queued and in-flight requests
//   busy   FIFO non-empty or any pipeline stage valid
module data_mem_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int TAG_W   = 5,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   data_mem_unit_if.slave bus,
   input  logic          flush,
   output logic          busy
);
   localparam int BE_W  = DATA_W / 8;
   localparam int PW    = $clog2(QDEPTH);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PW:0] FULL = (PW + 1)'(QDEPTH);

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   entry_t            fifo [QDEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;

   // Contents are not reset; a store that issued before a reset stays written.
   logic [DATA_W-1:0] mem [DEPTH];

   logic [LATENCY-1:0] st_valid;
   logic [LATENCY-1:0] st_store;
   logic [TAG_W-1:0]   st_tag  [LATENCY];
   logic [DATA_W-1:0]  st_data [LATENCY];

   entry_t            head, incoming;
   logic [DATA_W-1:0] rd_word;
   logic              push, pop, stall;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

   assign incoming = '{we:   bus.req_we,
                       be:   bus.req_be,
                       addr: bus.req_addr[ADDR_W-1:0],
                       data: bus.req_data,
                       tag:  bus.req_tag};

   assign head    = fifo[rd_ptr];
   assign rd_word = mem[head.addr];

   // The whole pipeline freezes while the last stage holds an untaken response.
   assign stall         = st_valid[LATENCY-1] && !bus.resp_ready;
   assign bus.req_ready = (count != FULL);
   assign push          = bus.req_valid && bus.req_ready && !flush;
   assign pop           = (count != '0) && !stall && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= incoming;
   end

   always_ff @(posedge clk) begin
      if (pop && head.we) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (head.be[i]) mem[head.addr][8*i +: 8] <= head.data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_valid <= '0;
         st_store <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            st_tag[i]  <= '0;
            st_data[i] <= '0;
         end
      end else if (flush) begin
         st_valid <= '0;
      end else if (!stall) begin
         // Stage 0 takes a bubble when the FIFO is empty (pop low).
         st_valid[0] <= pop;
         st_store[0] <= head.we;
         st_tag[0]   <= head.tag;
         st_data[0]  <= head.we ? '0 : rd_word;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_store[i] <= st_store[i-1];
            st_tag[i]   <= st_tag[i-1];
            st_data[i]  <= st_data[i-1];
         end
      end
   end

   assign bus.resp_valid    = st_valid[LATENCY-1];
   assign bus.resp_is_store = st_store[LATENCY-1];
   assign bus.resp_tag      = st_tag[LATENCY-1];
   assign bus.resp_data     = st_data[LATENCY-1];

   assign busy = (count != '0) || (|st_valid);
endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: an in-order request queue and a word
// array model the expected responses; directed scenarios add literal checks.
module tb_data_mem_unit;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 10;
   localparam int TAG_W   = 5;
   localparam int LATENCY = 2;
   localparam int QDEPTH  = 4;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc;

   data_mem_unit_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   data_mem_unit #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
      .LATENCY(LATENCY), .QDEPTH(QDEPTH)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .flush(flush), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [4:0]  tag;
   } req_t;

   req_t        pend[$];
   req_t        h, nr;
   logic [31:0] mm [1024];
   logic [31:0] exp_data;

   int          log_n = 0;
   logic [4:0]  log_tag  [64];
   logic [31:0] log_data [64];
   logic        log_st   [64];
   int          log_cyc  [64];

   initial for (int i = 0; i < 1024; i++) mm[i] = '0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_resp_valid", bus.resp_valid, 0);
         chk("rst_busy", busy, 0);
         pend.delete();
      end else begin
         chk("busy", busy, pend.size() != 0);
         if (bus.resp_valid) begin
            if (pend.size() == 0) begin
               chk("spurious_resp", bus.resp_valid, 0);
            end else begin
               h = pend[0];
               exp_data = h.we ? 32'h0 : mm[h.addr];
               chk("resp_tag", bus.resp_tag, h.tag);
               chk("resp_is_store", bus.resp_is_store, h.we);
               chk("resp_data", bus.resp_data, exp_data);
               if (bus.resp_ready) begin
                  if (h.we) mm[h.addr] = merge(mm[h.addr], h.data, h.be);
                  if (log_n < 64) begin
                     log_tag[log_n]  = bus.resp_tag;
                     log_data[log_n] = bus.resp_data;
                     log_st[log_n]   = bus.resp_is_store;
                     log_cyc[log_n]  = cyc;
                     log_n++;
                  end
                  void'(pend.pop_front());
               end
            end
         end
         if (flush) begin
            pend.delete();
         end else if (bus.req_valid && bus.req_ready) begin
            nr.we   = bus.req_we;
            nr.be   = bus.req_be;
            nr.addr = bus.req_addr[9:0];
            nr.data = bus.req_data;
            nr.tag  = bus.req_tag;
            pend.push_back(nr);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] tag);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_be    = be;
      bus.req_addr  = addr;
      bus.req_data  = data;
      bus.req_tag   = tag;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            acc_cyc = cyc;
            return;
         end
      end
      chk("send_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("drain_idle", busy, 0);
      @(posedge clk);
      #1;
   endtask

   int first_acc;

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_be = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.req_tag = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_resp_valid", bus.resp_valid, 0);
      chk("reset_resp_tag", bus.resp_tag, 0);
      chk("reset_resp_data", bus.resp_data, 0);
      chk("reset_resp_is_store", bus.resp_is_store, 0);
      chk("reset_busy", busy, 0);
      chk("reset_req_ready", bus.req_ready, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // load after store
      log_n = 0;
      send(1'b1, 4'hF, 32'd5, 32'hDEADBEEF, 5'd3);
      send(1'b0, 4'h0, 32'd5, 32'h0, 5'd4);
      drain();
      chk("las_count", log_n, 2);
      chk("las_tag0", log_tag[0], 3);
      chk("las_store0", log_st[0], 1);
      chk("las_data0", log_data[0], 0);
      chk("las_tag1", log_tag[1], 4);
      chk("las_store1", log_st[1], 0);
      chk("las_data1", log_data[1], 32'hDEADBEEF);
      chk("load_latency", log_cyc[1] - acc_cyc, LATENCY);

      // byte enables
      log_n = 0;
      send(1'b1, 4'hF, 32'd7, 32'h11223344, 5'd1);
      send(1'b1, 4'b0101, 32'd7, 32'hAABBCCDD, 5'd2);
      send(1'b0, 4'h0, 32'd7, 32'h0, 5'd6);
      drain();
      chk("be_data", log_data[2], 32'h11BB33DD);

      // backpressure: 8 loads, responses held
      log_n = 0;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == QDEPTH + LATENCY) begin
            repeat (4) @(posedge clk);
            #1;
            chk("bp_req_ready_low", bus.req_ready, 0);
            chk("bp_held_valid", bus.resp_valid, 1);
            chk("bp_held_tag", bus.resp_tag, 8);
            chk("bp_held_data", bus.resp_data, 32'h11BB33DD);
            chk("bp_no_delivery", log_n, 0);
            bus.resp_ready = 1'b1;
         end
         send(1'b0, 4'h0, (i % 2 == 0) ? 32'd7 : 32'd5, 32'h0, 5'(8 + i));
      end
      drain();
      chk("bp_count", log_n, 8);
      for (int i = 0; i < 8; i++) chk($sformatf("bp_order%0d", i), log_tag[i], 8 + i);

      // flush with 3 queued and 2 in flight
      send(1'b1, 4'hF, 32'd9, 32'hCAFEF00D, 5'd22);
      drain();
      log_n = 0;
      bus.resp_ready = 1'b0;
      send(1'b0, 4'h0, 32'd9, 32'h0, 5'd16);
      send(1'b0, 4'h0, 32'd9, 32'h0, 5'd17);
      send(1'b1, 4'hF, 32'd9, 32'h12345678, 5'd18);
      send(1'b0, 4'h0, 32'd9, 32'h0, 5'd19);
      send(1'b0, 4'h0, 32'd9, 32'h0, 5'd20);
      chk("pre_flush_busy", busy, 1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_resp_valid", bus.resp_valid, 0);
      chk("flush_req_ready", bus.req_ready, 1);
      bus.resp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("flush_no_resp", log_n, 0);
      send(1'b0, 4'h0, 32'd9, 32'h0, 5'd21);
      drain();
      chk("flush_store_dropped", log_data[0], 32'hCAFEF00D);

      // async reset mid-stream
      bus.resp_ready = 1'b0;
      send(1'b0, 4'h0, 32'd5, 32'h0, 5'd1);
      send(1'b0, 4'h0, 32'd5, 32'h0, 5'd2);
      send(1'b0, 4'h0, 32'd5, 32'h0, 5'd3);
      chk("pre_reset_valid", bus.resp_valid, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_resp_valid", bus.resp_valid, 0);
      chk("async_rst_req_ready", bus.req_ready, 1);
      chk("async_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;

      // address aliasing
      log_n = 0;
      send(1'b1, 4'hF, 32'h400, 32'h55AA00FF, 5'd1);
      send(1'b0, 4'h0, 32'h0, 32'h0, 5'd2);
      drain();
      chk("alias_data", log_data[1], 32'h55AA00FF);

      // 20 back-to-back loads across FIFO wrap
      log_n = 0;
      first_acc = 0;
      for (int i = 0; i < 20; i++) begin
         send(1'b0, 4'h0, 32'(i % 8), 32'h0, 5'(i));
         if (i == 0) first_acc = acc_cyc;
      end
      chk("wrap_throughput", acc_cyc - first_acc, 19);
      drain();
      chk("wrap_count", log_n, 20);
      for (int i = 0; i < 20; i++) chk($sformatf("wrap_order%0d", i), log_tag[i], i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
